// File: rtl/ibuffer_pkg.sv
// Shared types and constants for the instruction buffer that sits between
// the fetch unit and the decoder.
package ibuffer_pkg;

  localparam int IBUF_DEPTH = 8;
  localparam int PC_WIDTH   = 48;

  typedef struct packed {
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] pc;
    logic                predicttaken;
    logic [31:0]         predicttarget;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuffer_entry_ram.sv
// Entry storage for the instruction buffer: one synchronous write port and
// one asynchronous read port. Contents are never reset.
module ibuffer_entry_ram
  import ibuffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             write_en,
  input  logic [PTR_W-1:0] write_addr,
  input  ibuf_entry_t      write_data,
  input  logic [PTR_W-1:0] read_addr,
  output ibuf_entry_t      read_data
);

  ibuf_entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/ibuffer.sv
// Circular instruction FIFO between fetch and decode. The head entry is shown
// first-word-fall-through, and a flush empties the buffer in one cycle.
module ibuffer #(
  parameter int DEPTH    = 8,
  parameter int PC_WIDTH = 48,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush_valid,
  input  logic                ifu2ibuf_instr_valid,
  output logic                ifu2ibuf_instr_ready,
  input  logic [31:0]         ifu_inst,
  input  logic [PC_WIDTH-1:0] ifu_pc,
  input  logic                ifu_predicttaken,
  input  logic [31:0]         ifu_predicttarget,
  input  logic                ibuffer_read_en,
  output logic                fifo_empty,
  output logic                ibuffer_instr_valid,
  output logic [31:0]         ibuffer_inst_out,
  output logic [PC_WIDTH-1:0] ibuffer_pc_out,
  output logic                ibuffer_predicttaken_out,
  output logic [31:0]         ibuffer_predicttarget_out,
  output logic [PTR_W:0]      ibuffer_count
);

  import ibuffer_pkg::*;

  // The stored PC field has the package width; PC_WIDTH here is expected to match it.
  localparam int ENTRY_PC_W = ibuffer_pkg::PC_WIDTH;

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           full;
  logic           push;
  logic           pop;
  ibuf_entry_t    write_entry;
  ibuf_entry_t    head_entry;

  assign ibuffer_count = wr_ptr - rd_ptr;
  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                         (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

  // Ready depends only on occupancy, so a pop never opens a slot in the same cycle.
  assign ifu2ibuf_instr_ready = !full;
  assign ibuffer_instr_valid  = !fifo_empty && !flush_valid;

  assign push = ifu2ibuf_instr_valid && ifu2ibuf_instr_ready && !flush_valid;
  assign pop  = ibuffer_read_en && ibuffer_instr_valid;

  always_ff @(posedge clock) begin
    if (reset || flush_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    write_entry               = '0;
    write_entry.inst          = ifu_inst;
    write_entry.pc            = ENTRY_PC_W'(ifu_pc);
    write_entry.predicttaken  = ifu_predicttaken;
    write_entry.predicttarget = ifu_predicttarget;
  end

  ibuffer_entry_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_entry_ram (
    .clock      (clock),
    .write_en   (push && !reset),
    .write_addr (wr_ptr[PTR_W-1:0]),
    .write_data (write_entry),
    .read_addr  (rd_ptr[PTR_W-1:0]),
    .read_data  (head_entry)
  );

  // Storage is never reset, so the head is masked to keep stale words off the bus.
  assign ibuffer_inst_out          = fifo_empty ? '0 : head_entry.inst;
  assign ibuffer_pc_out            = fifo_empty ? '0 : PC_WIDTH'(head_entry.pc);
  assign ibuffer_predicttaken_out  = fifo_empty ? 1'b0 : head_entry.predicttaken;
  assign ibuffer_predicttarget_out = fifo_empty ? '0 : head_entry.predicttarget;

endmodule

// File: tb/tb_ibuffer.sv
// Bench for ibuffer: a queue model checked every cycle, plus hand-computed
// literal expectations for the directed scenarios.
module tb_ibuffer;

  localparam int DEPTH = 8;
  localparam int PC_W  = 48;
  localparam int PTR_W = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush_valid;
  logic              ifu2ibuf_instr_valid;
  logic              ifu2ibuf_instr_ready;
  logic [31:0]       ifu_inst;
  logic [PC_W-1:0]   ifu_pc;
  logic              ifu_predicttaken;
  logic [31:0]       ifu_predicttarget;
  logic              ibuffer_read_en;
  logic              fifo_empty;
  logic              ibuffer_instr_valid;
  logic [31:0]       ibuffer_inst_out;
  logic [PC_W-1:0]   ibuffer_pc_out;
  logic              ibuffer_predicttaken_out;
  logic [31:0]       ibuffer_predicttarget_out;
  logic [PTR_W:0]    ibuffer_count;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [31:0]     target;
  } model_entry_t;

  model_entry_t model_q[$];

  ibuffer #(
    .DEPTH    (DEPTH),
    .PC_WIDTH (PC_W)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .flush_valid               (flush_valid),
    .ifu2ibuf_instr_valid      (ifu2ibuf_instr_valid),
    .ifu2ibuf_instr_ready      (ifu2ibuf_instr_ready),
    .ifu_inst                  (ifu_inst),
    .ifu_pc                    (ifu_pc),
    .ifu_predicttaken          (ifu_predicttaken),
    .ifu_predicttarget         (ifu_predicttarget),
    .ibuffer_read_en           (ibuffer_read_en),
    .fifo_empty                (fifo_empty),
    .ibuffer_instr_valid       (ibuffer_instr_valid),
    .ibuffer_inst_out          (ibuffer_inst_out),
    .ibuffer_pc_out            (ibuffer_pc_out),
    .ibuffer_predicttaken_out  (ibuffer_predicttaken_out),
    .ibuffer_predicttarget_out (ibuffer_predicttarget_out),
    .ibuffer_count             (ibuffer_count)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: FIFO queue updated from the inputs seen at each rising edge.
  always @(posedge clock) begin
    bit do_push;
    bit do_pop;
    model_entry_t e;
    if (reset || flush_valid) begin
      model_q.delete();
    end else begin
      do_push = ifu2ibuf_instr_valid && (model_q.size() < DEPTH);
      do_pop  = ibuffer_read_en && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.inst   = ifu_inst;
        e.pc     = ifu_pc;
        e.taken  = ifu_predicttaken;
        e.target = ifu_predicttarget;
        model_q.push_back(e);
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      check_output("cmp_count", 64'(ibuffer_count), 64'(model_q.size()));
      check_output("cmp_empty", 64'(fifo_empty), 64'(model_q.size() == 0));
      check_output("cmp_ready", 64'(ifu2ibuf_instr_ready), 64'(model_q.size() < DEPTH));
      check_output("cmp_valid", 64'(ibuffer_instr_valid),
                   64'((model_q.size() > 0) && !flush_valid));
      if (model_q.size() > 0) begin
        check_output("cmp_inst", 64'(ibuffer_inst_out), 64'(model_q[0].inst));
        check_output("cmp_pc", 64'(ibuffer_pc_out), 64'(model_q[0].pc));
        check_output("cmp_taken", 64'(ibuffer_predicttaken_out), 64'(model_q[0].taken));
        check_output("cmp_target", 64'(ibuffer_predicttarget_out), 64'(model_q[0].target));
      end else begin
        check_output("cmp_data_zero",
                     64'(ibuffer_inst_out | ibuffer_predicttarget_out |
                         32'(ibuffer_predicttaken_out)) | 64'(ibuffer_pc_out), 64'd0);
      end
    end
  end

  task automatic apply_stimulus(input logic v, input logic [PC_W-1:0] pc,
                                input logic [31:0] inst, input logic rd,
                                input logic fl);
    ifu2ibuf_instr_valid = v;
    ifu_pc               = pc;
    ifu_inst             = inst;
    ifu_predicttaken     = pc[2];
    ifu_predicttarget    = inst ^ 32'h8000_0000;
    ibuffer_read_en      = rd;
    flush_valid          = fl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n, input logic [PC_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b1, base + PC_W'(i * 4), 32'h100 + 32'(i), 1'b0, 1'b0);
      step();
    end
    idle();
  endtask

  task automatic drain();
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (DEPTH + 1) step();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) step();
    reset = 1'b0;
    check_en = 1'b1;
    step();

    check_output("rst_empty", 64'(fifo_empty), 64'd1);
    check_output("rst_valid", 64'(ibuffer_instr_valid), 64'd0);
    check_output("rst_ready", 64'(ifu2ibuf_instr_ready), 64'd1);
    check_output("rst_count", 64'(ibuffer_count), 64'd0);
    check_output("rst_pc", 64'(ibuffer_pc_out), 64'd0);
    check_output("rst_inst", 64'(ibuffer_inst_out), 64'd0);

    apply_stimulus(1'b1, 48'h1000, 32'h0000_0013, 1'b0, 1'b0);
    step();
    idle();
    check_output("single_valid", 64'(ibuffer_instr_valid), 64'd1);
    check_output("single_pc", 64'(ibuffer_pc_out), 64'h1000);
    check_output("single_inst", 64'(ibuffer_inst_out), 64'h13);
    check_output("single_count", 64'(ibuffer_count), 64'd1);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    idle();
    check_output("single_pop_empty", 64'(fifo_empty), 64'd1);

    fill(DEPTH, 48'h3000);
    check_output("full_count", 64'(ibuffer_count), 64'd8);
    check_output("full_ready", 64'(ifu2ibuf_instr_ready), 64'd0);
    apply_stimulus(1'b1, 48'h4000, 32'hBAD, 1'b0, 1'b0);
    repeat (2) step();
    idle();
    check_output("ninth_rejected", 64'(ibuffer_count), 64'd8);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    idle();
    check_output("after_pop_ready", 64'(ifu2ibuf_instr_ready), 64'd1);
    check_output("after_pop_count", 64'(ibuffer_count), 64'd7);
    check_output("after_pop_head", 64'(ibuffer_pc_out), 64'h3004);
    drain();

    fill(3, 48'h5000);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 48'h5100 + PC_W'(i * 4), 32'h200 + 32'(i), 1'b1, 1'b0);
      step();
      check_output("stream_count", 64'(ibuffer_count), 64'd3);
    end
    idle();
    check_output("stream_head", 64'(ibuffer_pc_out), 64'h5100 + 64'(17 * 4));
    drain();

    fill(5, 48'h6000);
    apply_stimulus(1'b1, 48'hDEAD, 32'hDEAD, 1'b1, 1'b1);
    #1;
    check_output("flush_valid_low", 64'(ibuffer_instr_valid), 64'd0);
    step();
    idle();
    check_output("flush_count", 64'(ibuffer_count), 64'd0);
    step();
    check_output("flush_no_ghost", 64'(fifo_empty), 64'd1);

    fill(DEPTH, 48'h6800);
    apply_stimulus(1'b1, 48'hBEEF, 32'hBEEF, 1'b1, 1'b1);
    step();
    idle();
    check_output("flush_full_count", 64'(ibuffer_count), 64'd0);

    fill(6, 48'h7000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("midrst_count", 64'(ibuffer_count), 64'd0);
    check_output("midrst_empty", 64'(fifo_empty), 64'd1);
    apply_stimulus(1'b1, 48'h2000, 32'h33, 1'b0, 1'b0);
    step();
    idle();
    check_output("midrst_head_pc", 64'(ibuffer_pc_out), 64'h2000);
    check_output("midrst_head_valid", 64'(ibuffer_instr_valid), 64'd1);
    step();

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
